// File: rtl/motor_spi_pkg.sv
// Shared frame layout, FSM states and helpers for the motor-board SPI responder.
// 32-bit frames, MSB first; MOSI carries control, MISO carries motor status.
package motor_spi_pkg;

  localparam int FRAME_BITS = 32;
  localparam int BIT_CNT_W  = 6;
  localparam int ENC_W      = 15;
  localparam int HALL_W     = 7;
  localparam int DUTY_W     = 10;

  localparam logic [BIT_CNT_W-1:0] BIT_CNT_FULL = BIT_CNT_W'(FRAME_BITS);
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_SAT  = BIT_CNT_W'(FRAME_BITS + 1);
  localparam logic [7:0]           SYNC_BYTE    = 8'hA5;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2,
    COMMIT    = 2'd3
  } spi_state_e;

  typedef struct packed {
    logic              wr_en;
    logic              rst_cnt;
    logic [3:0]        rsvd;
    logic [DUTY_W-1:0] duty;
    logic [15:0]       ignored;
  } mosi_frame_t;

  typedef struct packed {
    logic [ENC_W-1:0]  enc_count;
    logic [HALL_W-1:0] hall_count;
    logic              hall_fault;
    logic              frame_error;
    logic [7:0]        sync;
  } miso_frame_t;

  function automatic miso_frame_t build_miso(input logic [ENC_W-1:0]  enc,
                                             input logic [HALL_W-1:0] hall,
                                             input logic              fault,
                                             input logic              ferr);
    miso_frame_t f;
    f.enc_count   = enc;
    f.hall_count  = hall;
    f.hall_fault  = fault;
    f.frame_error = ferr;
    f.sync        = SYNC_BYTE;
    return f;
  endfunction

endpackage

// File: rtl/motor_spi_slave_sync_edge.sv
// Two-flop synchronizer with one-cycle rise/fall pulses in the clock domain.
// Level and edge outputs lag the pin by two clocks; no backpressure.
module spi_sync_edge (
  input  logic clock_i,
  input  logic reset_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Resetting low means a reset taken with cs_n held low cannot fabricate a falling edge.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/motor_spi_slave.sv
// SPI mode-0 responder: MCU writes duty/count-reset, reads encoder/hall status; watchdog kills motor.
// Outputs update 4 clocks after cs_n rises at the pin; the SPI master is never stalled.
module motor_spi_slave
  import motor_spi_pkg::*;
#(
  parameter int DUTY_CYCLE_WIDTH = 10,
  parameter int ENC_COUNT_WIDTH  = 15,
  parameter int HALL_COUNT_WIDTH = 7,
  parameter int WATCHDOG_CYCLES  = 1000000
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        spi_sclk_i,
  input  logic                        spi_cs_n_i,
  input  logic                        spi_mosi_i,
  output logic                        spi_miso_o,
  output logic                        spi_miso_oe_o,
  input  logic [ENC_COUNT_WIDTH-1:0]  enc_count_i,
  input  logic [HALL_COUNT_WIDTH-1:0] hall_count_i,
  input  logic                        hall_fault_i,
  output logic [DUTY_CYCLE_WIDTH-1:0] duty_cycle_o,
  output logic                        motor_en_o,
  output logic                        reset_counts_o,
  output logic                        frame_error_o
);

  localparam int              WD_W   = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WATCHDOG_CYCLES);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic cs_n_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge u_sync_sclk (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .d_i     (spi_sclk_i),
    .level_o (sclk_lvl_unused),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  spi_sync_edge u_sync_cs_n (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .d_i     (spi_cs_n_i),
    .level_o (cs_n_lvl),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  spi_sync_edge u_sync_mosi (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .d_i     (spi_mosi_i),
    .level_o (mosi_lvl),
    .rise_o  (mosi_rise_unused),
    .fall_o  (mosi_fall_unused)
  );

  spi_state_e                  state_q;
  logic [FRAME_BITS-1:0]       tx_q;
  logic [FRAME_BITS-1:0]       rx_q;
  logic [BIT_CNT_W-1:0]        bit_cnt_q;
  logic [DUTY_CYCLE_WIDTH-1:0] duty_q;
  logic                        motor_en_q;
  logic                        reset_counts_q;
  logic                        frame_error_q;
  logic                        miso_q;
  logic                        miso_oe_q;
  logic [WD_W-1:0]             wd_q;
  logic [WD_W-1:0]             wd_d;

  mosi_frame_t           rx_frame;
  miso_frame_t           snap;
  logic [FRAME_BITS-1:0] snap_bits;
  logic                  frame_ok;
  logic                  commit_ok;
  logic                  wd_expire;

  assign rx_frame  = mosi_frame_t'(rx_q);
  assign snap      = build_miso(ENC_W'(enc_count_i), HALL_W'(hall_count_i),
                                hall_fault_i, frame_error_q);
  assign snap_bits = snap;
  assign frame_ok  = (bit_cnt_q == BIT_CNT_FULL);
  assign commit_ok = (state_q == COMMIT) && frame_ok;

  // A valid commit reloads to zero, so it always beats expiry in the same cycle.
  always_comb begin
    wd_d = wd_q;
    if (commit_ok) begin
      wd_d = '0;
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + 1'b1;
    end
  end

  assign wd_expire = (wd_d == WD_MAX);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= WAIT_IDLE;
      tx_q           <= '0;
      rx_q           <= '0;
      bit_cnt_q      <= '0;
      duty_q         <= '0;
      motor_en_q     <= 1'b0;
      reset_counts_q <= 1'b0;
      frame_error_q  <= 1'b0;
      miso_q         <= 1'b0;
      miso_oe_q      <= 1'b0;
    end else begin
      reset_counts_q <= 1'b0;
      if (wd_expire) begin
        duty_q     <= '0;
        motor_en_q <= 1'b0;
      end
      case (state_q)
        WAIT_IDLE: begin
          if (cs_n_lvl) begin
            state_q <= IDLE;
          end
        end
        IDLE: begin
          if (cs_fall) begin
            tx_q      <= snap_bits;
            miso_q    <= snap_bits[FRAME_BITS-1];
            miso_oe_q <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          // End of frame drops any sclk edge seen in the same cycle.
          if (cs_rise) begin
            state_q <= COMMIT;
          end else begin
            if (sclk_rise) begin
              rx_q <= {rx_q[FRAME_BITS-2:0], mosi_lvl};
              if (bit_cnt_q != BIT_CNT_SAT) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
            if (sclk_fall) begin
              tx_q   <= {tx_q[FRAME_BITS-2:0], 1'b0};
              miso_q <= tx_q[FRAME_BITS-2];
            end
          end
        end
        COMMIT: begin
          state_q   <= IDLE;
          miso_oe_q <= 1'b0;
          miso_q    <= 1'b0;
          if (frame_ok) begin
            if (rx_frame.wr_en) begin
              duty_q     <= rx_frame.duty[DUTY_CYCLE_WIDTH-1:0];
              motor_en_q <= 1'b1;
            end
            reset_counts_q <= rx_frame.rst_cnt;
            frame_error_q  <= 1'b0;
          end else begin
            frame_error_q <= 1'b1;
          end
        end
        default: begin
          state_q <= WAIT_IDLE;
        end
      endcase
    end
  end

  assign spi_miso_o     = miso_q;
  assign spi_miso_oe_o  = miso_oe_q;
  assign duty_cycle_o   = duty_q;
  assign motor_en_o     = motor_en_q;
  assign reset_counts_o = reset_counts_q;
  assign frame_error_o  = frame_error_q;

endmodule

// File: tb/tb_motor_spi_slave.sv
// Directed bench for motor_spi_slave: readback, write, count reset, bad frames, watchdog, reset.
// The watchdog is shortened to 100 cycles so its timeout is reachable.
module tb_motor_spi_slave;

  localparam int H = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic        oe;
  logic [14:0] enc;
  logic [6:0]  hall;
  logic        fault;
  logic [9:0]  duty;
  logic        motor_en;
  logic        rc;
  logic        ferr;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  motor_spi_slave #(
    .DUTY_CYCLE_WIDTH (10),
    .ENC_COUNT_WIDTH  (15),
    .HALL_COUNT_WIDTH (7),
    .WATCHDOG_CYCLES  (100)
  ) dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .spi_sclk_i     (sclk),
    .spi_cs_n_i     (cs_n),
    .spi_mosi_i     (mosi),
    .spi_miso_o     (miso),
    .spi_miso_oe_o  (oe),
    .enc_count_i    (enc),
    .hall_count_i   (hall),
    .hall_fault_i   (fault),
    .duty_cycle_o   (duty),
    .motor_en_o     (motor_en),
    .reset_counts_o (rc),
    .frame_error_o  (ferr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Master side of one frame; MISO is sampled just before each sclk rise.
  task automatic spi_xfer(input logic [31:0] mosi_w, input int nbits, input int chg_bit,
                          output logic [31:0] miso_w, output logic oe_mid);
    miso_w = '0;
    oe_mid = 1'b0;
    @(negedge clk);
    cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mosi_w[31 - (i % 32)];
      if (i == chg_bit) begin
        enc   = '0;
        hall  = '0;
        fault = 1'b0;
      end
      repeat (H) @(negedge clk);
      miso_w = {miso_w[30:0], miso};
      if (i == 16) oe_mid = oe;
      sclk = 1'b1;
      repeat (H) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (H) @(negedge clk);
    cs_n = 1'b1;
    mosi = 1'b0;
  endtask

  logic [31:0] w;
  logic        om;
  logic        oe_seen;

  initial begin
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    enc = '0; hall = '0; fault = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_duty", duty, 0);
    check("rst_motor_en", motor_en, 0);
    check("rst_reset_counts", rc, 0);
    check("rst_miso", miso, 0);
    check("rst_miso_oe", oe, 0);
    check("rst_frame_error", ferr, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Readback; inputs change mid-frame but the snapshot must hold.
    enc = 15'h1234; hall = 7'h55; fault = 1'b1;
    spi_xfer(32'h0000_0000, 32, 4, w, om);
    check("t1_miso_word", w, 32'h2469_56A5);
    check("t1_oe_mid", om, 1);
    clocks(4);
    check("t1_oe_after", oe, 0);
    check("t1_motor_en", motor_en, 0);
    check("t1_frame_error", ferr, 0);

    // Write with exact 4-clock latency.
    spi_xfer(32'h800F_0000, 32, -1, w, om);
    clocks(3);
    check("t2_duty_pre", duty, 0);
    check("t2_motor_pre", motor_en, 0);
    clocks(1);
    check("t2_duty", duty, 10'h00F);
    check("t2_motor_en", motor_en, 1);
    check("t2_rc_commit", rc, 0);
    clocks(1);
    check("t2_rc_next", rc, 0);

    // Count reset; the frame outlasts the watchdog, so duty is already forced off.
    spi_xfer(32'h4000_0000, 32, -1, w, om);
    clocks(3);
    check("t3_rc_pre", rc, 0);
    clocks(1);
    check("t3_rc_pulse", rc, 1);
    check("t3_duty", duty, 0);
    clocks(1);
    check("t3_rc_end", rc, 0);

    // Short frame carrying a write must not commit.
    spi_xfer(32'h8155_0000, 20, -1, w, om);
    clocks(4);
    check("t4_duty", duty, 0);
    check("t4_motor_en", motor_en, 0);
    check("t4_frame_error", ferr, 1);
    check("t4_rc", rc, 0);
    enc = 15'h7FFF; hall = 7'h00; fault = 1'b0;
    spi_xfer(32'h0000_0000, 32, -1, w, om);
    check("t4_miso_word", w, 32'hFFFE_01A5);
    clocks(4);
    check("t4_ferr_cleared", ferr, 0);

    // Over-long frame is also rejected.
    spi_xfer(32'h80AA_0000, 34, -1, w, om);
    clocks(4);
    check("t4b_duty", duty, 0);
    check("t4b_frame_error", ferr, 1);

    // Watchdog expiry and recovery.
    spi_xfer(32'h8123_0000, 32, -1, w, om);
    clocks(4);
    check("t5_duty", duty, 10'h123);
    check("t5_frame_error", ferr, 0);
    clocks(98);
    check("t5_duty_alive", duty, 10'h123);
    check("t5_motor_alive", motor_en, 1);
    clocks(2);
    check("t5_duty_timeout", duty, 0);
    check("t5_motor_timeout", motor_en, 0);
    spi_xfer(32'h8045_0000, 32, -1, w, om);
    clocks(4);
    check("t5_duty_restore", duty, 10'h045);
    check("t5_motor_restore", motor_en, 1);

    // Async reset mid-frame with cs_n held low.
    @(negedge clk);
    cs_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mosi = 1'b1;
      repeat (H) @(negedge clk);
      sclk = 1'b1;
      repeat (H) @(negedge clk);
      sclk = 1'b0;
    end
    check("t6_duty_pre", duty, 10'h045);
    check("t6_oe_pre", oe, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_duty", duty, 0);
    check("t6_rst_motor_en", motor_en, 0);
    check("t6_rst_oe", oe, 0);
    check("t6_rst_miso", miso, 0);
    check("t6_rst_rc", rc, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    oe_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      repeat (H) @(negedge clk);
      oe_seen = oe_seen | oe;
      sclk = 1'b1;
      repeat (H) @(negedge clk);
      oe_seen = oe_seen | oe;
      sclk = 1'b0;
    end
    check("t6_no_response", oe_seen, 0);
    cs_n = 1'b1;
    mosi = 1'b0;
    clocks(4);
    check("t6_no_commit_ferr", ferr, 0);
    repeat (6) @(negedge clk);
    enc = 15'h0001; hall = 7'h7F; fault = 1'b0;
    spi_xfer(32'h82AA_0000, 32, -1, w, om);
    check("t6_miso_word", w, 32'h0003_FCA5);
    check("t6_oe_mid", om, 1);
    clocks(4);
    check("t6_duty", duty, 10'h2AA);
    check("t6_motor_en", motor_en, 1);
    check("t6_frame_error", ferr, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
